grid_walker: RTL and testbench

GRID_WALKER -- requirements
Module: grid_walker

---
 rtl/grid_walker.sv | 138 +++++++++++++
 tb/tb_grid_walker.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/grid_walker.sv
// Grid walker: accepts direction/step-count commands and walks a point one cell per clock
// across a bounded grid, either saturating at the edges or wrapping toroidally.
module grid_walker #(
  parameter int COORD_W = 5,
  parameter int STEP_W  = 2,
  parameter int MAX_X   = 15,
  parameter int MAX_Y   = 15,
  parameter int WRAP    = 0,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_dir,
  input  logic [STEP_W-1:0]  cmd_steps,
  output logic [COORD_W-1:0] outx,
  output logic [COORD_W-1:0] outy,
  output logic               busy,
  output logic               done,
  output logic               hit_wall,
  output logic [CNT_W-1:0]   move_count
);

  localparam logic [COORD_W-1:0] LIM_X = COORD_W'(MAX_X);
  localparam logic [COORD_W-1:0] LIM_Y = COORD_W'(MAX_Y);
  localparam bit                 DO_WRAP = (WRAP != 0);

  typedef enum logic {
    IDLE = 1'b0,
    MOVE = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          dir_q, dir_d;
  logic [STEP_W-1:0]   rem_q, rem_d;
  logic [COORD_W-1:0]  x_q, x_d;
  logic [COORD_W-1:0]  y_q, y_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                done_q, done_d;
  logic                hit_q, hit_d;

  logic                isX;
  logic                plus;
  logic [COORD_W-1:0]  cur;
  logic [COORD_W-1:0]  lim;
  logic                atEdge;
  logic [COORD_W-1:0]  nextCoord;

  // dir[1] selects the axis (0 = x), dir[0] selects the sign (0 = increasing).
  always_comb begin
    isX       = ~dir_q[1];
    plus      = ~dir_q[0];
    cur       = isX ? x_q : y_q;
    lim       = isX ? LIM_X : LIM_Y;
    atEdge    = plus ? (cur == lim) : (cur == '0);
    nextCoord = plus ? (cur + COORD_W'(1)) : (cur - COORD_W'(1));
    if (atEdge) begin
      nextCoord = plus ? '0 : lim;
    end
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    rem_d   = rem_q;
    x_d     = x_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    hit_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_steps == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = MOVE;
            dir_d   = cmd_dir;
            rem_d   = cmd_steps;
          end
        end
      end
      MOVE: begin
        // A saturating walker stops the whole command at the first blocked cell.
        if (atEdge && !DO_WRAP) begin
          done_d  = 1'b1;
          hit_d   = 1'b1;
          state_d = IDLE;
        end else begin
          if (isX) begin
            x_d = nextCoord;
          end else begin
            y_d = nextCoord;
          end
          cnt_d = cnt_q + CNT_W'(1);
          rem_d = rem_q - STEP_W'(1);
          if (rem_q == STEP_W'(1)) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dir_q   <= '0;
      rem_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      rem_q   <= rem_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      hit_q   <= hit_d;
    end
  end

  assign cmd_ready  = (state_q == IDLE);
  assign busy       = (state_q == MOVE);
  assign outx       = x_q;
  assign outy       = y_q;
  assign done       = done_q;
  assign hit_wall   = hit_q;
  assign move_count = cnt_q;

endmodule

// File: tb/tb_grid_walker.sv
// Bench for grid_walker: a saturating and a wrapping instance driven by directed and random
// commands, each edge compared against a per-command trajectory model.
module tb_grid_walker;

  localparam int MAXX = 15;
  localparam int MAXY = 15;

  logic       clk;
  logic       rst;
  logic       cmdValid [2];
  logic [1:0] cmdDir   [2];
  logic [1:0] cmdSteps [2];
  logic       cmdReady [2];
  logic [4:0] outX     [2];
  logic [4:0] outY     [2];
  logic       busy     [2];
  logic       done     [2];
  logic       hitWall  [2];
  logic [15:0] moveCount [2];

  int assertCount = 0;
  int failCount   = 0;
  int mx [2];
  int my [2];
  int mcnt [2];

  grid_walker #(.WRAP(0)) uSat (
    .clk(clk), .rst(rst), .cmd_valid(cmdValid[0]), .cmd_ready(cmdReady[0]),
    .cmd_dir(cmdDir[0]), .cmd_steps(cmdSteps[0]), .outx(outX[0]), .outy(outY[0]),
    .busy(busy[0]), .done(done[0]), .hit_wall(hitWall[0]), .move_count(moveCount[0])
  );

  grid_walker #(.WRAP(1)) uWrap (
    .clk(clk), .rst(rst), .cmd_valid(cmdValid[1]), .cmd_ready(cmdReady[1]),
    .cmd_dir(cmdDir[1]), .cmd_steps(cmdSteps[1]), .outx(outX[1]), .outy(outY[1]),
    .busy(busy[1]), .done(done[1]), .hit_wall(hitWall[1]), .move_count(moveCount[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    assertCount++;
    if (observed != expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // One unit move along an axis of size m+1; blocked only when saturating at an edge.
  function automatic int stepAxis(input int c, input int delta, input int m,
                                  input bit wrap, output bit blocked);
    blocked = 1'b0;
    if (wrap) return (c + delta + m + 1) % (m + 1);
    if ((delta > 0 && c == m) || (delta < 0 && c == 0)) begin
      blocked = 1'b1;
      return c;
    end
    return c + delta;
  endfunction

  task automatic checkPosition(input int inst, input string tag);
    checkOutput({tag, "_x"}, int'(outX[inst]), mx[inst]);
    checkOutput({tag, "_y"}, int'(outY[inst]), my[inst]);
    checkOutput({tag, "_cnt"}, int'(moveCount[inst]), mcnt[inst]);
  endtask

  task automatic resetAll();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) cmdValid[i] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mx[i] = 0; my[i] = 0; mcnt[i] = 0;
      checkPosition(i, "reset");
      checkOutput("reset_done", int'(done[i]), 0);
      checkOutput("reset_hit", int'(hitWall[i]), 0);
      checkOutput("reset_ready", int'(cmdReady[i]), 1);
      checkOutput("reset_busy", int'(busy[i]), 0);
    end
  endtask

  // Issues one command and follows it edge by edge; with hold, cmd_valid stays high afterwards.
  task automatic applyStimulus(input int inst, input int d, input int k, input bit hold);
    bit wrap, axisX, blocked, isLast;
    int delta, cur, m, nxt;
    wrap  = (inst == 1);
    axisX = (d < 2);
    delta = (d == 0 || d == 2) ? 1 : -1;
    checkOutput("ready_before_cmd", int'(cmdReady[inst]), 1);
    cmdValid[inst] = 1'b1;
    cmdDir[inst]   = 2'(d);
    cmdSteps[inst] = 2'(k);
    @(posedge clk); #1;
    if (!hold) cmdValid[inst] = 1'b0;
    if (k == 0) begin
      checkOutput("zero_done", int'(done[inst]), 1);
      checkOutput("zero_hit", int'(hitWall[inst]), 0);
      checkOutput("zero_busy", int'(busy[inst]), 0);
      checkOutput("zero_ready", int'(cmdReady[inst]), 1);
      checkPosition(inst, "zero");
      return;
    end
    checkOutput("accept_busy", int'(busy[inst]), 1);
    checkOutput("accept_ready", int'(cmdReady[inst]), 0);
    checkOutput("accept_done", int'(done[inst]), 0);
    for (int i = 1; i <= k; i++) begin
      @(posedge clk); #1;
      cur = axisX ? mx[inst] : my[inst];
      m   = axisX ? MAXX : MAXY;
      nxt = stepAxis(cur, delta, m, wrap, blocked);
      if (!blocked) begin
        if (axisX) mx[inst] = nxt; else my[inst] = nxt;
        mcnt[inst] = (mcnt[inst] + 1) % 65536;
      end
      isLast = blocked || (i == k);
      checkPosition(inst, "move");
      checkOutput("move_done", int'(done[inst]), int'(isLast));
      checkOutput("move_hit", int'(hitWall[inst]), int'(blocked));
      checkOutput("move_busy", int'(busy[inst]), int'(!isLast));
      checkOutput("move_ready", int'(cmdReady[inst]), int'(isLast));
      if (isLast) break;
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      cmdValid[i] = 1'b0; cmdDir[i] = '0; cmdSteps[i] = '0;
    end
    rst = 1'b1;
    resetAll();

    // Basic east walk, then march to x=14 and run into the east wall.
    applyStimulus(0, 0, 3, 1'b0);
    applyStimulus(0, 0, 3, 1'b0);
    applyStimulus(0, 0, 3, 1'b0);
    applyStimulus(0, 0, 3, 1'b0);
    applyStimulus(0, 0, 2, 1'b0);
    checkOutput("x_at_14", int'(outX[0]), 14);
    applyStimulus(0, 0, 3, 1'b0);
    checkOutput("x_at_wall", int'(outX[0]), 15);

    // Wrapping west from the origin.
    applyStimulus(1, 1, 2, 1'b0);
    checkOutput("wrap_x", int'(outX[1]), 14);

    // Zero-step command, then back-to-back commands with cmd_valid held high.
    applyStimulus(0, 2, 0, 1'b0);
    applyStimulus(0, 2, 3, 1'b0);
    applyStimulus(0, 3, 3, 1'b1);
    applyStimulus(0, 3, 3, 1'b1);
    cmdValid[0] = 1'b0;
    applyStimulus(1, 3, 3, 1'b1);
    applyStimulus(1, 3, 3, 1'b1);
    cmdValid[1] = 1'b0;
    @(posedge clk); #1;
    checkOutput("idle_done", int'(done[1]), 0);

    // Reset in the middle of a three-step east move aborts it silently.
    resetAll();
    cmdValid[0] = 1'b1; cmdDir[0] = 2'd0; cmdSteps[0] = 2'd3;
    @(posedge clk); #1;
    cmdValid[0] = 1'b0;
    @(posedge clk); #1;
    checkOutput("abort_x1", int'(outX[0]), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("abort_x", int'(outX[0]), 0);
    checkOutput("abort_done", int'(done[0]), 0);
    checkOutput("abort_ready", int'(cmdReady[0]), 1);
    checkOutput("abort_cnt", int'(moveCount[0]), 0);
    @(posedge clk); #1;
    checkOutput("abort_done_late", int'(done[0]), 0);
    checkOutput("abort_x_late", int'(outX[0]), 0);
    for (int i = 0; i < 2; i++) begin
      mx[i] = 0; my[i] = 0; mcnt[i] = 0;
    end

    // Random walks on both instances.
    for (int inst = 0; inst < 2; inst++) begin
      for (int n = 0; n < 80; n++) begin
        applyStimulus(inst, int'($urandom_range(3, 0)), int'($urandom_range(3, 0)),
                      1'($urandom_range(1, 0)));
      end
      cmdValid[inst] = 1'b0;
      @(posedge clk); #1;
      checkPosition(inst, "random_end");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
